// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main control FSM: outputs decode the current state; lw 5, beq 3, others 4 cycles.
// Wait states (FETCH/MEMREAD/MEMWRITE) stall on mem_ready=0 with strobes held low (MemWrite held high).
module multicycle_main_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t state, state_nxt;
  logic   ready;
  logic   branch_s, pc_update_s, reg_write_s, mem_write_s, ir_write_s, done_s, illegal_s;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    branch_s    = 1'b0;
    pc_update_s = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        ir_write_s  = ready;
        pc_update_s = ready;
        if (ready) state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_nxt = MEMADR;
          7'b0110011:             state_nxt = EXECUTER;
          7'b0010011:             state_nxt = EXECUTEI;
          7'b1100011:             state_nxt = BEQ;
          7'b1101111:             state_nxt = JAL;
          default:                state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_nxt = MEMWB;
      end
      MEMWRITE: begin
        // The write strobe stays up across stalls; memory takes it on the ready cycle.
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        done_s      = ready;
        if (ready) state_nxt = FETCH;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
        state_nxt   = FETCH;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
        state_nxt   = FETCH;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b01;
        branch_s  = 1'b1;
        done_s    = 1'b1;
        state_nxt = FETCH;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
        state_nxt   = ALUWB;
      end
      TRAP: begin
        illegal_s = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes drop combinationally on reset assertion, without waiting for an edge.
  assign Branch        = branch_s    & rst_n;
  assign PCUpdate      = pc_update_s & rst_n;
  assign RegWrite      = reg_write_s & rst_n;
  assign MemWrite      = mem_write_s & rst_n;
  assign IRWrite       = ir_write_s  & rst_n;
  assign instr_done    = done_s      & rst_n;
  assign illegal_instr = illegal_s   & rst_n;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class cycle by cycle.
module tb_multicycle_main_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal_instr;
  logic [3:0] state_o;
  logic [15:0] obs;

  int total = 0;
  int bad   = 0;

  multicycle_main_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_instr};

  // Expected output vector, fields in the same order as obs.
  function automatic logic [15:0] ov(input logic br, input logic pc, input logic rw,
                                     input logic mw, input logic ir, input logic adr,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] aop,
                                     input logic dn, input logic il);
    return {br, pc, rw, mw, ir, adr, rs, sa, sb, aop, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply mem_ready, check the current state and outputs, then advance one clock.
  task automatic step(input string tag, input logic rdy, input logic [3:0] st,
                      input logic [15:0] vec);
    mem_ready = rdy;
    #1;
    chk({tag, "_state"}, {28'd0, state_o}, {28'd0, st});
    chk({tag, "_out"}, {16'd0, obs}, {16'd0, vec});
    @(posedge clk);
    #1;
  endtask

  logic [15:0] v_rst, v_fetch, v_fetch_w, v_dec, v_exei, v_exer, v_aluwb, v_madr;
  logic [15:0] v_mrd, v_mwb, v_mwr_w, v_mwr, v_beq, v_jal, v_trap;

  initial begin
    v_rst     = ov(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
    v_fetch   = ov(0,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,0,0);
    v_fetch_w = v_rst;
    v_dec     = ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0);
    v_exei    = ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0);
    v_exer    = ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
    v_aluwb   = ov(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0);
    v_madr    = ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0);
    v_mrd     = ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0);
    v_mwb     = ov(0,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0);
    v_mwr_w   = ov(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0);
    v_mwr     = ov(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,1,0);
    v_beq     = ov(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0);
    v_jal     = ov(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0);
    v_trap    = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);

    rst_n = 1'b0;
    op = 7'b0010011;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // In reset the FETCH selects show but IRWrite/PCUpdate stay low despite mem_ready=1.
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_out", {16'd0, obs}, {16'd0, v_rst});
    rst_n = 1'b1;

    // I-type ALU
    step("i_fetch", 1, 4'd0, v_fetch);
    step("i_dec",   1, 4'd1, v_dec);
    step("i_exe",   1, 4'd7, v_exei);
    step("i_wb",    1, 4'd8, v_aluwb);

    // lw with a fetch stall and two MEMREAD stall cycles
    op = 7'b0000011;
    step("lw_fetch_w", 0, 4'd0, v_fetch_w);
    step("lw_fetch",   1, 4'd0, v_fetch);
    step("lw_dec",     1, 4'd1, v_dec);
    step("lw_adr",     1, 4'd2, v_madr);
    step("lw_rd_w0",   0, 4'd3, v_mrd);
    step("lw_rd_w1",   0, 4'd3, v_mrd);
    step("lw_rd",      1, 4'd3, v_mrd);
    step("lw_wb",      1, 4'd4, v_mwb);

    // R-type ALU
    op = 7'b0110011;
    step("r_fetch", 1, 4'd0, v_fetch);
    step("r_dec",   1, 4'd1, v_dec);
    step("r_exe",   1, 4'd6, v_exer);
    step("r_wb",    1, 4'd8, v_aluwb);

    // beq: three cycles
    op = 7'b1100011;
    step("beq_fetch", 1, 4'd0, v_fetch);
    step("beq_dec",   1, 4'd1, v_dec);
    step("beq_exe",   1, 4'd9, v_beq);

    // jal
    op = 7'b1101111;
    step("jal_fetch", 1, 4'd0, v_fetch);
    step("jal_dec",   1, 4'd1, v_dec);
    step("jal_exe",   1, 4'd10, v_jal);
    step("jal_wb",    1, 4'd8, v_aluwb);

    // sw with one MEMWRITE stall: MemWrite high for both cycles
    op = 7'b0100011;
    step("sw_fetch", 1, 4'd0, v_fetch);
    step("sw_dec",   1, 4'd1, v_dec);
    step("sw_adr",   1, 4'd2, v_madr);
    step("sw_wr_w",  0, 4'd5, v_mwr_w);
    step("sw_wr",    1, 4'd5, v_mwr);

    // sw with ready on entry: single write cycle, straight back to FETCH
    step("sw2_fetch", 1, 4'd0, v_fetch);
    step("sw2_dec",   1, 4'd1, v_dec);
    step("sw2_adr",   1, 4'd2, v_madr);
    step("sw2_wr",    1, 4'd5, v_mwr);
    step("sw2_back",  1, 4'd0, v_fetch);

    // Illegal opcode: trap and no further fetches
    op = 7'b0000000;
    step("ill_dec", 1, 4'd1, v_dec);
    for (int i = 0; i < 20; i++) step("ill_trap", 1, 4'd11, v_trap);

    // Reset clears the trap
    rst_n = 1'b0;
    #1;
    chk("trap_rst_out", {16'd0, obs}, {16'd0, v_rst});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset pulse while stalled in MEMWRITE
    op = 7'b0100011;
    step("swr_fetch", 1, 4'd0, v_fetch);
    step("swr_dec",   1, 4'd1, v_dec);
    step("swr_adr",   1, 4'd2, v_madr);
    mem_ready = 1'b0;
    #1;
    chk("swr_mw_pre", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("swr_mw_drop", {31'd0, MemWrite}, 32'd0);
    chk("swr_rst_state", {28'd0, state_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("swr_rst_out", {16'd0, obs}, {16'd0, v_rst});
    rst_n = 1'b1;
    step("swr_re_fetch", 1, 4'd0, v_fetch);
    step("swr_re_dec",   1, 4'd1, v_dec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
